// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer: radix-2 restoring divider plus mult latency counter.
// Latency: DIV/DIVU with a non-zero divisor stalls 33 cycles and has the result in DONE on cycle 34. Divide-by-zero stalls 1 cycle. Mult-class ops stall MUL_LAT+1 cycles.
// Backpressure: stallreq holds EX while busy. hold freezes DONE and divres. flush aborts any op.
module muldiv_ctrl #(
  parameter int          MUL_LAT  = 1,
  parameter logic [31:0] DIV0_QUO = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic        op_mul,
  input  logic [31:0] opr1,
  input  logic [31:0] opr2,
  output logic        stallreq,
  output logic        div_done,
  output logic [63:0] divres
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] dvd, dvs, rem, quo;
  logic        qsign, rsign;

  logic        is_div, start, div_zero;
  logic        s1, s2;
  logic [31:0] abs1, abs2;
  logic [32:0] trial;
  logic [31:0] rem_step, quo_step;
  logic        last_iter, mul_last;

  assign is_div    = op_div | op_divu;
  assign start     = (op_div | op_divu | op_mul) & ~flush;
  assign div_zero  = (opr2 == 32'd0);
  assign s1        = op_div & opr1[31];
  assign s2        = op_div & opr2[31];
  // Magnitudes wrap naturally, so 0x80000000 stays 0x80000000 as an unsigned value.
  assign abs1      = s1 ? -opr1 : opr1;
  assign abs2      = s2 ? -opr2 : opr2;

  // One restoring step: shift the next dividend bit into the remainder and try subtracting.
  assign trial     = {rem, dvd[31]} - {1'b0, dvs};
  assign rem_step  = trial[32] ? {rem[30:0], dvd[31]} : trial[31:0];
  assign quo_step  = {quo[30:0], ~trial[32]};
  assign last_iter = (cnt == 5'd31);
  assign mul_last  = (cnt == 5'(MUL_LAT - 1));

  assign div_done  = (state == DONE);

  // Next-state and stall request; flush overrides everything.
  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_div) begin
            state_nxt = div_zero ? DONE : DIV;
            stallreq  = 1'b1;
          end else if (MUL_LAT > 0) begin
            state_nxt = MUL;
            stallreq  = 1'b1;
          end
        end
      end
      MUL: begin
        stallreq = 1'b1;
        if (mul_last) state_nxt = DONE;
      end
      DIV: begin
        stallreq = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        // The finishing instruction is still in EX here, so never restart from DONE.
        if (!hold) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      stallreq  = 1'b0;
    end
  end

  // State, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      dvd    <= 32'd0;
      dvs    <= 32'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      divres <= 64'd0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        cnt <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= 5'd0;
            if (start && is_div) begin
              if (div_zero) begin
                divres <= {opr1, DIV0_QUO};
              end else begin
                dvd   <= abs1;
                dvs   <= abs2;
                rem   <= 32'd0;
                quo   <= 32'd0;
                qsign <= s1 ^ s2;
                rsign <= s1;
              end
            end
          end
          MUL: begin
            cnt <= mul_last ? 5'd0 : cnt + 5'd1;
          end
          DIV: begin
            rem <= rem_step;
            quo <= quo_step;
            dvd <= {dvd[30:0], 1'b0};
            cnt <= cnt + 5'd1;
            // The remainder takes the dividend's sign, the quotient the XOR of both signs.
            if (last_iter)
              divres <= {rsign ? -rem_step : rem_step, qsign ? -quo_step : quo_step};
          end
          default: cnt <= 5'd0;
        endcase
      end
    end
  end

endmodule
